fetch_predict: RTL and testbench

- Instruction fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a variable-latency instruction-memory handshake.
- Predicts branches with a direct-mapped BTB/BHT (2-bit saturating counters) and presents one instruction slot per cycle to IF/ID.
- Handles stalls with a one-entry hold buffer and accepts redirects from the resolve stage.

---
 rtl/fetch_predict.sv | 175 +++++++++++++++++
 tb/tb_fetch_predict.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_predict.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory handshake,
// predicts branches with a direct-mapped BTB/BHT and feeds one slot per cycle to IF/ID.
module fetch_predict #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int          BHT_BITS = 6
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IM_REQ,
    output logic [31:0] IM_ADDR,
    input  logic        IM_VALID,
    input  logic [31:0] IM_DATA,
    input  logic        BP_UPDATE,
    input  logic [31:0] BP_UPDATE_PC,
    input  logic        BP_TAKEN,
    input  logic [31:0] BP_TARGET,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4,
    output logic        Branch_prediction_OUT,
    output logic [31:0] Pred_Target_OUT
);
    localparam int ENTRIES = 1 << BHT_BITS;
    localparam int TAG_W   = 30 - BHT_BITS;

    // Memory handshake: IM_REQ/IM_ADDR are held until IM_VALID pulses for that
    // address, or until a redirect abandons the request.
    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        pred;
        logic [31:0] tgt;
    } slot_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    slot_t       slot_q, slot_d;
    slot_t       buf_q, buf_d;
    logic        buf_valid_q, buf_valid_d;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];

    logic [BHT_BITS-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]    up_tag;
    logic                lk_hit, lk_pred, up_hit;
    logic [31:0]         pc_plus4, next_pc;
    slot_t               fetched;
    logic                unused_bits;

    assign unused_bits = ^BP_UPDATE_PC[1:0];

    // Lookup reads only the registered tables, so a same-cycle update is not visible.
    always_comb begin
        lk_idx   = pc_q[BHT_BITS+1:2];
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == pc_q[31:BHT_BITS+2]);
        lk_pred  = lk_hit && ctr_q[lk_idx][1];
        pc_plus4 = pc_q + 32'd4;
        next_pc  = lk_pred ? target_q[lk_idx] : pc_plus4;
        fetched.instr = IM_DATA;
        fetched.pc    = pc_q;
        fetched.pc4   = pc_plus4;
        fetched.pred  = lk_pred;
        fetched.tgt   = lk_pred ? target_q[lk_idx] : 32'd0;
    end

    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        up_idx   = BP_UPDATE_PC[BHT_BITS+1:2];
        up_tag   = BP_UPDATE_PC[31:BHT_BITS+2];
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        if (BP_UPDATE) begin
            if (up_hit) begin
                if (BP_TAKEN) begin
                    if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'b01;
                    target_d[up_idx] = BP_TARGET;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'b01;
                end
            end else if (BP_TAKEN) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = BP_TARGET;
                ctr_d[up_idx]    = 2'b10;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        slot_d      = slot_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        if (REDIRECT) begin
            slot_d      = '0;
            buf_valid_d = 1'b0;
            pc_d        = REDIRECT_PC;
            state_d     = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (IM_VALID) begin
                        pc_d = next_pc;
                        if (STALL) begin
                            buf_d       = fetched;
                            buf_valid_d = 1'b1;
                            state_d     = HOLD;
                        end else begin
                            slot_d = fetched;
                        end
                    end else if (!STALL) begin
                        slot_d = '0;
                    end
                end
                HOLD: begin
                    if (!STALL) begin
                        slot_d      = buf_valid_q ? buf_q : '0;
                        buf_valid_d = 1'b0;
                        state_d     = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            slot_q      <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            valid_q     <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            slot_q      <= slot_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            valid_q     <= valid_d;
            ctr_q       <= ctr_d;
        end
    end

    // Tags and targets are qualified by the valid bits, so they need no reset.
    always_ff @(posedge CLK) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign IM_REQ                = (state_q == FETCH);
    assign IM_ADDR               = pc_q;
    assign Instr1_OUT            = slot_q.instr;
    assign Instr_PC_OUT          = slot_q.pc;
    assign Instr_PC_Plus4        = slot_q.pc4;
    assign Branch_prediction_OUT = slot_q.pred;
    assign Pred_Target_OUT       = slot_q.tgt;
endmodule

// File: tb/tb_fetch_predict.sv
// Directed bench for fetch_predict: reset, streaming, stall hold, prediction
// training/saturation and redirect behaviour with hand-computed expectations.
module tb_fetch_predict;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        STALL = 1'b0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = '0;
    logic        IM_REQ;
    logic [31:0] IM_ADDR;
    logic        IM_VALID = 1'b0;
    logic [31:0] IM_DATA = '0;
    logic        BP_UPDATE = 1'b0;
    logic [31:0] BP_UPDATE_PC = '0;
    logic        BP_TAKEN = 1'b0;
    logic [31:0] BP_TARGET = '0;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4;
    logic        Branch_prediction_OUT;
    logic [31:0] Pred_Target_OUT;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_pc;

    fetch_predict dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .REDIRECT(REDIRECT),
        .REDIRECT_PC(REDIRECT_PC), .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR),
        .IM_VALID(IM_VALID), .IM_DATA(IM_DATA), .BP_UPDATE(BP_UPDATE),
        .BP_UPDATE_PC(BP_UPDATE_PC), .BP_TAKEN(BP_TAKEN), .BP_TARGET(BP_TARGET),
        .Instr1_OUT(Instr1_OUT), .Instr_PC_OUT(Instr_PC_OUT),
        .Instr_PC_Plus4(Instr_PC_Plus4), .Branch_prediction_OUT(Branch_prediction_OUT),
        .Pred_Target_OUT(Pred_Target_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_req", IM_REQ, 1);
        chk("rst_addr", IM_ADDR, 32'hBFC00000);
        chk("rst_instr", Instr1_OUT, 0);
        chk("rst_pc", Instr_PC_OUT, 0);
        chk("rst_pred", Branch_prediction_OUT, 0);
        RESET = 1'b1;

        // first fetch at zero latency
        IM_VALID = 1; IM_DATA = 32'h24080001; tick();
        chk("f0_instr", Instr1_OUT, 32'h24080001);
        chk("f0_pc", Instr_PC_OUT, 32'hBFC00000);
        chk("f0_pc4", Instr_PC_Plus4, 32'hBFC00004);
        chk("f0_addr", IM_ADDR, 32'hBFC00004);

        // accepted under stall, then 3 stalled cycles
        STALL = 1; IM_DATA = 32'h11111111; tick();
        chk("st_req0", IM_REQ, 0);
        chk("st_hold0", Instr1_OUT, 32'h24080001);
        IM_VALID = 0; tick(); tick();
        chk("st_req2", IM_REQ, 0);
        chk("st_hold2", Instr1_OUT, 32'h24080001);
        chk("st_holdpc", Instr_PC_OUT, 32'hBFC00000);
        STALL = 0; tick();
        chk("st_buf_instr", Instr1_OUT, 32'h11111111);
        chk("st_buf_pc", Instr_PC_OUT, 32'hBFC00004);
        chk("st_buf_pc4", Instr_PC_Plus4, 32'hBFC00008);
        chk("st_req_back", IM_REQ, 1);
        chk("st_addr", IM_ADDR, 32'hBFC00008);
        IM_VALID = 1; IM_DATA = 32'h22222222; tick();
        chk("st_next_pc", Instr_PC_OUT, 32'hBFC00008);
        chk("st_next_addr", IM_ADDR, 32'hBFC0000C);

        // asynchronous reset while in HOLD
        STALL = 1; IM_DATA = 32'h33333333; tick();
        chk("hr_req_hold", IM_REQ, 0);
        IM_VALID = 0;
        #2 RESET = 0;
        #1;
        chk("hr_req", IM_REQ, 1);
        chk("hr_addr", IM_ADDR, 32'hBFC00000);
        chk("hr_instr", Instr1_OUT, 0);
        chk("hr_pc", Instr_PC_OUT, 0);
        chk("hr_pc4", Instr_PC_Plus4, 0);
        tick();
        RESET = 1; STALL = 0;
        IM_VALID = 1; IM_DATA = 32'h24080001; tick();
        chk("hr_f_instr", Instr1_OUT, 32'h24080001);
        chk("hr_f_pc", Instr_PC_OUT, 32'hBFC00000);
        chk("hr_f_pc4", Instr_PC_Plus4, 32'hBFC00004);
        chk("hr_f_addr", IM_ADDR, 32'hBFC00004);

        // two-cycle latency stream: bubble, instruction, ...
        exp_pc = 32'hBFC00004;
        for (int i = 0; i < 3; i++) begin
            IM_VALID = 0; tick();
            chk("str_bubble", Instr1_OUT, 0);
            chk("str_bubble_pc", Instr_PC_OUT, 0);
            chk("str_addr_held", IM_ADDR, exp_pc);
            IM_VALID = 1; IM_DATA = 32'h20000000 + i; tick();
            chk("str_instr", Instr1_OUT, 32'h20000000 + i);
            chk("str_pc", Instr_PC_OUT, exp_pc);
            exp_pc = exp_pc + 4;
        end
        IM_VALID = 0;

        // training: allocate taken entry at BFC00010
        BP_UPDATE = 1; BP_UPDATE_PC = 32'hBFC00010; BP_TAKEN = 1; BP_TARGET = 32'hBFC00100; tick();
        BP_UPDATE = 0; IM_VALID = 1; IM_DATA = 32'h10000004; tick();
        chk("tr_pred", Branch_prediction_OUT, 1);
        chk("tr_tgt", Pred_Target_OUT, 32'hBFC00100);
        chk("tr_pc", Instr_PC_OUT, 32'hBFC00010);
        chk("tr_addr", IM_ADDR, 32'hBFC00100);
        IM_VALID = 0;

        // two not-taken updates (first coincides with a redirect) -> ctr 00
        REDIRECT = 1; REDIRECT_PC = 32'hBFC00010; BP_UPDATE = 1; BP_TAKEN = 0; tick();
        chk("nt_redir_addr", IM_ADDR, 32'hBFC00010);
        chk("nt_redir_slot", Instr1_OUT, 0);
        REDIRECT = 0; tick();
        BP_UPDATE = 0; IM_VALID = 1; tick();
        chk("nt_pred", Branch_prediction_OUT, 0);
        chk("nt_tgt", Pred_Target_OUT, 0);
        chk("nt_addr", IM_ADDR, 32'hBFC00014);
        IM_VALID = 0;

        // saturation: 5 taken -> 11, 1 not-taken -> 10 still taken
        BP_UPDATE = 1; BP_TAKEN = 1; BP_TARGET = 32'hBFC00200;
        for (int i = 0; i < 5; i++) tick();
        BP_TAKEN = 0; tick();
        BP_UPDATE = 0; REDIRECT = 1; REDIRECT_PC = 32'hBFC00010; tick();
        REDIRECT = 0; IM_VALID = 1; tick();
        chk("sat_pred", Branch_prediction_OUT, 1);
        chk("sat_tgt", Pred_Target_OUT, 32'hBFC00200);
        chk("sat_addr", IM_ADDR, 32'hBFC00200);

        // same-cycle lookup and allocate at BFC00200: lookup sees the old table
        BP_UPDATE = 1; BP_UPDATE_PC = 32'hBFC00200; BP_TAKEN = 1; BP_TARGET = 32'h12345678; tick();
        chk("same_pred", Branch_prediction_OUT, 0);
        chk("same_pc", Instr_PC_OUT, 32'hBFC00200);
        chk("same_addr", IM_ADDR, 32'hBFC00204);
        BP_UPDATE = 0; IM_VALID = 0; REDIRECT = 1; REDIRECT_PC = 32'hBFC00200; tick();
        REDIRECT = 0; IM_VALID = 1; tick();
        chk("alloc_pred", Branch_prediction_OUT, 1);
        chk("alloc_addr", IM_ADDR, 32'h12345678);

        // redirect during stall with data arriving: data dropped
        STALL = 1; IM_DATA = 32'hDEADBEEF; REDIRECT = 1; REDIRECT_PC = 32'h80000180; tick();
        chk("rd_instr", Instr1_OUT, 0);
        chk("rd_pc", Instr_PC_OUT, 0);
        chk("rd_pred", Branch_prediction_OUT, 0);
        chk("rd_addr", IM_ADDR, 32'h80000180);
        chk("rd_req", IM_REQ, 1);
        REDIRECT = 0; STALL = 0; IM_VALID = 0; tick();
        chk("rd_no_buf", Instr1_OUT, 0);
        IM_VALID = 1; IM_DATA = 32'h3C1D0000; tick();
        chk("rd_f_instr", Instr1_OUT, 32'h3C1D0000);
        chk("rd_f_pc", Instr_PC_OUT, 32'h80000180);
        chk("rd_f_pc4", Instr_PC_Plus4, 32'h80000184);
        IM_VALID = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
